// File: rtl/transpose_compute_sequencer.sv
// ---------------------------------------------------------------------------
// transpose_compute_sequencer
//
// Control FSM for the transposed-convolution compute engine. One start pulse
// runs one tile through four phases:
//   LOAD_W  : diagonal weight load, one row per cycle (DIMENSION cycles)
//   CLEAR   : clear every row's partial sum (1 cycle)
//   COMPUTE : skewed ifmap/accumulate wavefront; row i active for i <= t < i+N
//   DRAIN   : eject one PE per cycle through the engine's diagonal mux;
//             the drain index only advances when out_stall is low
// followed by a one-cycle DONE state that pulses done.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous, active-high reset
//   start           begin a tile (sampled only in IDLE)
//   num_steps       accumulation length N (sampled with start)
//   abort           synchronous cancel of the running tile
//   out_stall       accumulation not ready; freezes the drain
//   busy            high in every state except IDLE
//   done            one-cycle pulse at tile completion
//   en_weight_load  per-row weight load enable
//   en_ifmap_load   per-row ifmap load enable
//   en_psum         per-row accumulate enable
//   clear_psum      per-row partial-sum clear
//   en_output       per-row output eject enable
//   ifmap_sel_ctrl  per-row ifmap source (0 external, 1 forwarded from row above)
//   done_select     output mux select (0..DIMENSION-1)
//
// All outputs are registered: they are decoded from the *next* state and
// counter values, so they line up with the state they describe.
// ---------------------------------------------------------------------------
module transpose_compute_sequencer #(
  parameter int DIMENSION = 16,
  parameter int STEP_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [STEP_W-1:0]    num_steps,
  input  logic                 abort,
  input  logic                 out_stall,
  output logic                 busy,
  output logic                 done,
  output logic [DIMENSION-1:0] en_weight_load,
  output logic [DIMENSION-1:0] en_ifmap_load,
  output logic [DIMENSION-1:0] en_psum,
  output logic [DIMENSION-1:0] clear_psum,
  output logic [DIMENSION-1:0] en_output,
  output logic [DIMENSION-1:0] ifmap_sel_ctrl,
  output logic [4:0]           done_select
);

  // The shared counter must hold t = N+DIMENSION-2 with N at its maximum,
  // hence one bit wider than num_steps.
  localparam int TW = STEP_W + 1;
  localparam int CW = $clog2(DIMENSION);

  localparam logic [DIMENSION-1:0] ROW0      = {{(DIMENSION-1){1'b0}}, 1'b1};
  // Row 0 always takes the external ifmap; every other row takes the
  // value forwarded from the row above it.
  localparam logic [DIMENSION-1:0] SEL_SKEW  = {{(DIMENSION-1){1'b1}}, 1'b0};
  localparam logic [TW-1:0]        LAST_ROW  = TW'(DIMENSION - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_CLEAR,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;      // c in LOAD_W, t in COMPUTE, k in DRAIN
  logic [STEP_W-1:0]     n_q, n_d;          // latched accumulation length

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIMENSION-1:0]  en_weight_load_q, en_weight_load_d;
  logic [DIMENSION-1:0]  en_ifmap_load_q,  en_ifmap_load_d;
  logic [DIMENSION-1:0]  en_psum_q,        en_psum_d;
  logic [DIMENSION-1:0]  clear_psum_q,     clear_psum_d;
  logic [DIMENSION-1:0]  en_output_q,      en_output_d;
  logic [DIMENSION-1:0]  ifmap_sel_ctrl_q, ifmap_sel_ctrl_d;
  logic [4:0]            done_select_q,    done_select_d;

  logic [TW-1:0]         last_t;
  logic                  zero_len_done;
  logic [DIMENSION-1:0]  row_active;

  assign last_t = TW'(n_q) + TW'(DIMENSION - 2);

  // -------------------------------------------------------------------------
  // Next-state and counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    n_d           = n_q;
    zero_len_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (num_steps != '0) begin
            state_d = ST_LOAD_W;
            cnt_d   = '0;
            n_d     = num_steps;
          end else begin
            // Empty tile: acknowledge with a done pulse, never go busy.
            zero_len_done = 1'b1;
          end
        end
      end

      ST_LOAD_W: begin
        if (cnt_q == LAST_ROW) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CLEAR: begin
        state_d = ST_COMPUTE;
        cnt_d   = '0;
      end

      ST_COMPUTE: begin
        if (cnt_q == last_t) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        // A PE counts as ejected only in a cycle the accumulator accepts it.
        if (!out_stall) begin
          if (cnt_q == LAST_ROW) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides every busy state, including DONE.
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode from the next state, so the registered outputs describe the
  // state being entered.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DIMENSION; i++) begin
      row_active[i] = (cnt_d >= TW'(i)) && (cnt_d < TW'(i) + TW'(n_d));
    end
  end

  always_comb begin
    busy_d           = (state_d != ST_IDLE);
    done_d           = zero_len_done || (state_d == ST_DONE);
    en_weight_load_d = '0;
    en_ifmap_load_d  = '0;
    en_psum_d        = '0;
    clear_psum_d     = '0;
    en_output_d      = '0;
    ifmap_sel_ctrl_d = '0;
    done_select_d    = '0;

    unique case (state_d)
      ST_LOAD_W: en_weight_load_d = ROW0 << cnt_d[CW-1:0];
      ST_CLEAR:  clear_psum_d     = '1;
      ST_COMPUTE: begin
        en_ifmap_load_d  = row_active;
        en_psum_d        = row_active;
        ifmap_sel_ctrl_d = SEL_SKEW;
      end
      ST_DRAIN: begin
        en_output_d   = ROW0 << cnt_d[CW-1:0];
        done_select_d = 5'(cnt_d);
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      n_q              <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      en_weight_load_q <= '0;
      en_ifmap_load_q  <= '0;
      en_psum_q        <= '0;
      clear_psum_q     <= '0;
      en_output_q      <= '0;
      ifmap_sel_ctrl_q <= '0;
      done_select_q    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      n_q              <= n_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      en_weight_load_q <= en_weight_load_d;
      en_ifmap_load_q  <= en_ifmap_load_d;
      en_psum_q        <= en_psum_d;
      clear_psum_q     <= clear_psum_d;
      en_output_q      <= en_output_d;
      ifmap_sel_ctrl_q <= ifmap_sel_ctrl_d;
      done_select_q    <= done_select_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign en_weight_load = en_weight_load_q;
  assign en_ifmap_load  = en_ifmap_load_q;
  assign en_psum        = en_psum_q;
  assign clear_psum     = clear_psum_q;
  assign en_output      = en_output_q;
  assign ifmap_sel_ctrl = ifmap_sel_ctrl_q;
  assign done_select    = done_select_q;

endmodule

// File: tb/tb_transpose_compute_sequencer.sv
// ---------------------------------------------------------------------------
// tb_transpose_compute_sequencer
//
// Self-checking bench. A cycle-indexed model (cycles since start, drain index)
// predicts every output and is compared against the DUT on each falling edge.
// Directed tiles additionally record traces that are checked against
// hand-computed cycle numbers and values.
// ---------------------------------------------------------------------------
module tb_transpose_compute_sequencer;

  localparam int D     = 16;
  localparam int MAXC  = 320;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_steps = '0;
  logic        abort = 1'b0;
  logic        out_stall = 1'b0;
  logic        busy, done;
  logic [15:0] en_weight_load, en_ifmap_load, en_psum, clear_psum, en_output, ifmap_sel_ctrl;
  logic [4:0]  done_select;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  transpose_compute_sequencer #(.DIMENSION(D), .STEP_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_steps      (num_steps),
    .abort          (abort),
    .out_stall      (out_stall),
    .busy           (busy),
    .done           (done),
    .en_weight_load (en_weight_load),
    .en_ifmap_load  (en_ifmap_load),
    .en_psum        (en_psum),
    .clear_psum     (clear_psum),
    .en_output      (en_output),
    .ifmap_sel_ctrl (ifmap_sel_ctrl),
    .done_select    (done_select)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: position in the tile counted in cycles since start.
  //   rel 1..D          weight load of row rel-1
  //   rel D+1           psum clear
  //   rel D+2..2D+N     wavefront, t = rel-D-2
  //   beyond            drain at index m_k, then the done cycle
  // -------------------------------------------------------------------------
  int m_active, m_rel, m_n, m_k, m_done_st, m_zero_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_rel <= 0; m_n <= 0; m_k <= 0; m_done_st <= 0; m_zero_done <= 0;
    end else begin
      m_zero_done <= 0;
      if (m_active == 0) begin
        if (start && !abort) begin
          if (num_steps != 0) begin
            m_active <= 1; m_rel <= 1; m_n <= int'(num_steps); m_k <= 0; m_done_st <= 0;
          end else begin
            m_zero_done <= 1;
          end
        end
      end else if (abort || m_done_st != 0) begin
        m_active <= 0; m_done_st <= 0;
      end else if (m_rel > 2 * D + m_n) begin
        if (!out_stall) begin
          if (m_k == D - 1) m_done_st <= 1;
          else              m_k <= m_k + 1;
        end
      end else begin
        m_rel <= m_rel + 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] e_w, e_ifm, e_psum, e_clr, e_out, e_selc;
    logic [4:0]  e_sel;
    logic        e_busy, e_done;
    int          t;
    if (cmp_en) begin
      e_w = '0; e_ifm = '0; e_psum = '0; e_clr = '0; e_out = '0; e_selc = '0;
      e_sel = '0; e_busy = 1'b0; e_done = 1'b0;
      if (m_active != 0) begin
        e_busy = 1'b1;
        if (m_done_st != 0) e_done = 1'b1;
        else if (m_rel <= D) e_w[m_rel-1] = 1'b1;
        else if (m_rel == D + 1) e_clr = 16'hFFFF;
        else if (m_rel <= 2 * D + m_n) begin
          t = m_rel - D - 2;
          e_selc = 16'hFFFE;
          for (int i = 0; i < D; i++) begin
            if (i <= t && t < i + m_n) begin
              e_ifm[i] = 1'b1;
              e_psum[i] = 1'b1;
            end
          end
        end else begin
          e_out[m_k] = 1'b1;
          e_sel = 5'(m_k);
        end
      end
      if (m_zero_done != 0) e_done = 1'b1;
      check("model.busy",           32'(busy),           32'(e_busy));
      check("model.done",           32'(done),           32'(e_done));
      check("model.en_weight_load", 32'(en_weight_load), 32'(e_w));
      check("model.en_ifmap_load",  32'(en_ifmap_load),  32'(e_ifm));
      check("model.en_psum",        32'(en_psum),        32'(e_psum));
      check("model.clear_psum",     32'(clear_psum),     32'(e_clr));
      check("model.en_output",      32'(en_output),      32'(e_out));
      check("model.ifmap_sel_ctrl", 32'(ifmap_sel_ctrl), 32'(e_selc));
      check("model.done_select",    32'(done_select),    32'(e_sel));
    end
  end

  // -------------------------------------------------------------------------
  // Directed tile runner. Cycle j = j-th cycle after the edge that samples
  // start. Inputs set at cycle j are sampled at the end of cycle j.
  // -------------------------------------------------------------------------
  logic [15:0] tr_w[MAXC], tr_ifm[MAXC], tr_psum[MAXC], tr_clr[MAXC], tr_out[MAXC], tr_selc[MAXC];
  logic [4:0]  tr_sel[MAXC];
  logic        tr_busy[MAXC], tr_done[MAXC];

  task automatic run_tile(input int n, input int cycles, input int stall_at, input int stall_len,
                          input int abort_at, input int restart_at, output int done_cyc);
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    num_steps = 8'(n);
    for (int j = 1; j <= cycles; j++) begin
      @(negedge clk);
      start     = (j == restart_at);
      num_steps = (j == restart_at) ? 8'd9 : 8'(n);
      out_stall = (j >= stall_at) && (j < stall_at + stall_len);
      abort     = (j == abort_at);
      tr_w[j] = en_weight_load; tr_ifm[j] = en_ifmap_load; tr_psum[j] = en_psum;
      tr_clr[j] = clear_psum; tr_out[j] = en_output; tr_selc[j] = ifmap_sel_ctrl;
      tr_sel[j] = done_select; tr_busy[j] = busy; tr_done[j] = done;
      if (done && done_cyc < 0) done_cyc = j;
    end
    start = 1'b0; out_stall = 1'b0; abort = 1'b0;
  endtask

  int dc;
  int n_done;

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.vectors", 32'(en_weight_load | en_psum | clear_psum | en_output | ifmap_sel_ctrl), 32'd0);
    #3 rst = 1'b0;

    // N=4, no stall; a start with N=9 mid-COMPUTE must be ignored
    run_tile(4, 56, 0, 0, 0, 20, dc);
    check("t2.w_first",   32'(tr_w[1]),       32'h0001);
    check("t2.w_last",    32'(tr_w[16]),      32'h8000);
    check("t2.w_after",   32'(tr_w[17]),      32'h0000);
    check("t2.clear",     32'(tr_clr[17]),    32'hFFFF);
    check("t2.ifm_t0",    32'(tr_ifm[18]),    32'h0001);
    check("t2.row15_pre", 32'(tr_psum[32][15]), 32'd0);
    check("t2.row15_on",  32'(tr_psum[33]),   32'hF000);
    check("t2.row15_end", 32'(tr_psum[36]),   32'h8000);
    check("t2.selc",      32'(tr_selc[36]),   32'hFFFE);
    check("t2.psum_off",  32'(tr_psum[37]),   32'h0000);
    check("t2.sel_first", 32'(tr_sel[37]),    32'd0);
    check("t2.sel_last",  32'(tr_sel[52]),    32'd15);
    check("t2.out_last",  32'(tr_out[52]),    32'h8000);
    check("t2.done_cyc",  32'(dc),            32'd53);
    check("t2.idle",      32'(tr_busy[54]),   32'd0);

    // Stall for 3 cycles while k=5 is shown
    run_tile(4, 58, 42, 3, 0, 0, dc);
    for (int j = 42; j <= 45; j++) begin
      check("t3.sel_hold", 32'(tr_sel[j]), 32'd5);
      check("t3.out_hold", 32'(tr_out[j]), 32'h0020);
    end
    check("t3.sel_next", 32'(tr_sel[46]), 32'd6);
    check("t3.done_cyc", 32'(dc), 32'd56);
    n_done = 0;
    for (int j = 1; j <= 58; j++) if (tr_done[j]) n_done++;
    check("t3.one_done", 32'(n_done), 32'd1);

    // N=0: done pulse only
    run_tile(0, 4, 0, 0, 0, 0, dc);
    check("t4.done_cyc", 32'(dc), 32'd1);
    check("t4.busy", 32'(tr_busy[1]), 32'd0);
    check("t4.done_once", 32'(tr_done[2]), 32'd0);

    // Abort at c=7 of LOAD_W, then a clean tile with N=3
    run_tile(4, 60, 0, 0, 8, 0, dc);
    check("t5.w_c7", 32'(tr_w[8]), 32'h0080);
    check("t5.busy_after", 32'(tr_busy[9]), 32'd0);
    check("t5.no_done", 32'(dc), 32'hFFFF_FFFF);
    run_tile(3, 56, 0, 0, 0, 0, dc);
    check("t5.clean_done", 32'(dc), 32'd52);

    // abort and start in the same IDLE cycle
    @(negedge clk);
    start = 1'b1; abort = 1'b1; num_steps = 8'd4;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t5b.busy", 32'(busy), 32'd0);
    check("t5b.done", 32'(done), 32'd0);

    // N=255
    run_tile(255, 310, 0, 0, 0, 0, dc);
    check("t6.row0_first", 32'(tr_psum[18][0]),  32'd1);
    check("t6.row0_last",  32'(tr_psum[272][0]), 32'd1);
    check("t6.row0_off",   32'(tr_psum[273][0]), 32'd0);
    check("t6.row15_pre",  32'(tr_psum[32][15]), 32'd0);
    check("t6.row15_last", 32'(tr_ifm[287][15]), 32'd1);
    check("t6.drain0",     32'(tr_out[288]),     32'h0001);
    check("t6.done_cyc",   32'(dc),              32'd304);

    // Reset asserted mid-COMPUTE takes effect without a clock edge
    run_tile(4, 25, 0, 0, 0, 0, dc);
    #3 rst = 1'b1;
    #1;
    check("t1.busy", 32'(busy), 32'd0);
    check("t1.psum", 32'(en_psum | en_ifmap_load), 32'd0);
    check("t1.selc", 32'(ifmap_sel_ctrl), 32'd0);
    @(negedge clk);
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t1.idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
